// File: rtl/instr_fetch.sv
// PC / fetch stage in front of a registered-read instruction memory.
// Captures each fetched word into IR or OPR; sticky fault on out-of-range fetch.
module instr_fetch #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 181
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              fetch_opr,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] opr,
  output logic [ADDR_W-1:0] pc,
  output logic              ready,
  output logic              fetch_done,
  output logic              fault
);

  typedef enum logic [1:0] {IDLE, READ, LATCH} state_t;

  // One extra bit so a depth of 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_next, eff_addr;
  logic [DATA_W-1:0]   ir_next, opr_next;
  logic                target, target_next;
  logic                fault_next, done_next;

  assign mem_addr     = pc;
  assign mem_write_en = 1'b0;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      ir         <= '0;
      opr        <= '0;
      target     <= 1'b0;
      fault      <= 1'b0;
      fetch_done <= 1'b0;
      ready      <= 1'b1;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ir         <= ir_next;
      opr        <= opr_next;
      target     <= target_next;
      fault      <= fault_next;
      fetch_done <= done_next;
      ready      <= (state_next == IDLE);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ir_next     = ir;
    opr_next    = opr;
    target_next = target;
    fault_next  = fault;
    done_next   = 1'b0;
    eff_addr    = jump_en ? jump_addr : pc;

    case (state)
      IDLE: begin
        pc_next = eff_addr;
        if (fetch_req && !fault) begin
          if ({1'b0, eff_addr} >= DEPTH) begin
            fault_next = 1'b1;
          end else begin
            state_next  = READ;
            target_next = fetch_opr;
          end
        end
      end
      READ: begin
        state_next = LATCH;
      end
      LATCH: begin
        if (target) opr_next = mem_rdata;
        else        ir_next  = mem_rdata;
        pc_next    = pc + ADDR_W'(1);
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic        fetch_opr = 1'b0;
  logic        jump_en = 1'b0;
  logic [15:0] jump_addr = '0;
  logic [15:0] mem_addr;
  logic        mem_write_en;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ir, opr, pc;
  logic        ready, fetch_done, fault;

  logic [15:0] ram [256];

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(181)) dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_opr(fetch_opr),
    .jump_en(jump_en), .jump_addr(jump_addr), .mem_addr(mem_addr),
    .mem_write_en(mem_write_en), .mem_rdata(mem_rdata), .ir(ir), .opr(opr),
    .pc(pc), .ready(ready), .fetch_done(fetch_done), .fault(fault)
  );

  always #5 clk = ~clk;

  // Instruction memory with one-cycle registered read.
  always @(posedge clk) mem_rdata <= ram[mem_addr[7:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a fetch occupies the stage for `busy` cycles and
  // then delivers ram[pc] to the chosen register and advances pc.
  logic [15:0] m_pc, m_ir, m_opr;
  logic        m_fault, m_tgt, m_done, prev_done;
  int          busy = 0;
  bit          mvalid = 0;

  always @(posedge clk) begin
    if (rst) begin
      mvalid = 1; busy = 0;
      m_pc = 0; m_ir = 0; m_opr = 0; m_fault = 0; m_tgt = 0; m_done = 0;
    end else if (mvalid) begin
      m_done = 0;
      if (busy == 0) begin
        if (jump_en) m_pc = jump_addr;
        if (fetch_req && !m_fault) begin
          if (m_pc >= 16'd181) m_fault = 1;
          else begin busy = 2; m_tgt = fetch_opr; end
        end
      end else if (busy == 2) begin
        busy = 1;
      end else begin
        if (m_tgt) m_opr = ram[m_pc[7:0]];
        else       m_ir  = ram[m_pc[7:0]];
        m_pc = m_pc + 16'd1;
        m_done = 1;
        busy = 0;
      end
    end
    #1;
    if (mvalid) begin
      check("pc",       32'(pc),           32'(m_pc));
      check("mem_addr", 32'(mem_addr),     32'(m_pc));
      check("ir",       32'(ir),           32'(m_ir));
      check("opr",      32'(opr),          32'(m_opr));
      check("ready",    32'(ready),        32'(busy == 0));
      check("done",     32'(fetch_done),   32'(m_done));
      check("fault",    32'(fault),        32'(m_fault));
      check("mem_we",   32'(mem_write_en), 32'd0);
      check("done_gap", 32'(fetch_done & prev_done), 32'd0);
      prev_done = fetch_done;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    prev_done = 0;
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 7 + 3);
    ram[0] = 16'd38; ram[1] = 16'd257; ram[132] = 16'd16; ram[172] = 16'd51;

    @(negedge clk);
    step(); step();
    rst = 0;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_opr", 32'(opr), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_done", 32'(fetch_done), 32'd0);

    // First fetch into IR
    fetch_req = 1; fetch_opr = 0;
    step(); fetch_req = 0;
    check("f1_busy0", 32'(ready), 32'd0);
    step();
    check("f1_busy1", 32'(ready), 32'd0);
    step();
    check("f1_ready", 32'(ready), 32'd1);
    check("f1_done", 32'(fetch_done), 32'd1);
    check("f1_ir", 32'(ir), 32'd38);
    check("f1_pc", 32'(pc), 32'd1);
    check("f1_opr", 32'(opr), 32'd0);

    // Back-to-back fetch into OPR issued in the done cycle
    fetch_req = 1; fetch_opr = 1;
    step(); fetch_req = 0; fetch_opr = 0;
    step(); step();
    check("f2_opr", 32'(opr), 32'd257);
    check("f2_ir", 32'(ir), 32'd38);
    check("f2_pc", 32'(pc), 32'd2);
    check("f2_done", 32'(fetch_done), 32'd1);

    // Jump alone, then fetch
    jump_en = 1; jump_addr = 16'd132;
    step(); jump_en = 0;
    check("j_pc", 32'(pc), 32'd132);
    check("j_ready", 32'(ready), 32'd1);
    fetch_req = 1;
    step(); fetch_req = 0;
    step(); step();
    check("j_ir", 32'(ir), 32'd16);
    check("j_pc2", 32'(pc), 32'd133);

    // Jump with fetch; a jump during READ is ignored
    jump_en = 1; fetch_req = 1; jump_addr = 16'd172;
    step(); fetch_req = 0; jump_addr = 16'd5;
    step(); jump_en = 0;
    step();
    check("jf_ir", 32'(ir), 32'd51);
    check("jf_pc", 32'(pc), 32'd173);

    // Out-of-range fetch faults; fault blocks later fetches until reset
    jump_en = 1; jump_addr = 16'd181;
    step(); jump_en = 0;
    fetch_req = 1;
    step(); fetch_req = 0;
    check("fl_fault", 32'(fault), 32'd1);
    check("fl_ready", 32'(ready), 32'd1);
    check("fl_pc", 32'(pc), 32'd181);
    check("fl_ir", 32'(ir), 32'd51);
    jump_en = 1; jump_addr = 16'd0;
    step(); jump_en = 0;
    fetch_req = 1;
    step(); fetch_req = 0;
    check("fl2_ready", 32'(ready), 32'd1);
    check("fl2_pc", 32'(pc), 32'd0);
    check("fl2_ir", 32'(ir), 32'd51);
    rst = 1;
    step(); rst = 0;
    check("fl_clr", 32'(fault), 32'd0);
    check("fl_clr_pc", 32'(pc), 32'd0);

    // Reset during LATCH aborts the fetch
    fetch_req = 1;
    step(); fetch_req = 0;
    step();
    rst = 1;
    step(); rst = 0;
    check("ab_ir", 32'(ir), 32'd0);
    check("ab_pc", 32'(pc), 32'd0);
    check("ab_done", 32'(fetch_done), 32'd0);
    check("ab_ready", 32'(ready), 32'd1);
    step();
    check("ab_done2", 32'(fetch_done), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      fetch_req = 1'($urandom);
      fetch_opr = 1'($urandom);
      jump_en   = ($urandom_range(0, 99) < 15);
      jump_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 190));
      step();
    end
    rst = 0; fetch_req = 0; jump_en = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
